// File: rtl/inst_fifo_if.sv
// inst_fifo_if: fetch push, issue pop and head-view signals of the instruction FIFO.
interface inst_fifo_if;
  logic        fifo_flush;
  logic        issue_stall;
  logic        w_ena_1;
  logic        w_ena_2;
  logic [31:0] w_pc_1;
  logic [31:0] w_inst_1;
  logic [31:0] w_pc_2;
  logic [31:0] w_inst_2;
  logic [1:0]  issue_num;
  logic        r_valid_1;
  logic        r_valid_2;
  logic [31:0] r_pc_1;
  logic [31:0] r_inst_1;
  logic [31:0] r_pc_2;
  logic [31:0] r_inst_2;
  logic        fifo_stall_req;
  modport master (
    output fifo_flush, issue_stall, w_ena_1, w_ena_2, w_pc_1, w_inst_1, w_pc_2, w_inst_2, issue_num,
    input  r_valid_1, r_valid_2, r_pc_1, r_inst_1, r_pc_2, r_inst_2, fifo_stall_req
  );
  modport slave (
    input  fifo_flush, issue_stall, w_ena_1, w_ena_2, w_pc_1, w_inst_1, w_pc_2, w_inst_2, issue_num,
    output r_valid_1, r_valid_2, r_pc_1, r_inst_1, r_pc_2, r_inst_2, fifo_stall_req
  );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: two-wide push / two-wide pop instruction queue between fetch and issue.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input logic        clk,
  input logic        rst,
  inst_fifo_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_LIM = (AW+1)'(DEPTH - 2);
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] rptr, wptr, rptr_1, wptr_1;
  logic [AW:0]   count;
  logic [1:0]    wn, rn, iss;
  assign rptr_1 = rptr + 1'b1;
  assign wptr_1 = wptr + 1'b1;
  // Stall leaves room for a full pair, so an accepted push can never overflow.
  assign f.fifo_stall_req = count > STALL_LIM;
  assign wn  = (f.fifo_stall_req || !f.w_ena_1) ? 2'd0 : (f.w_ena_2 ? 2'd2 : 2'd1);
  assign iss = f.issue_num[1] ? 2'd2 : f.issue_num;
  assign rn  = f.issue_stall ? 2'd0 : (((AW+1)'(iss) > count) ? count[1:0] : iss);
  assign f.r_valid_1 = count >= (AW+1)'(1);
  assign f.r_valid_2 = count >= (AW+1)'(2);
  assign f.r_pc_1    = f.r_valid_1 ? pc_mem[rptr]     : 32'h0;
  assign f.r_inst_1  = f.r_valid_1 ? inst_mem[rptr]   : 32'h0;
  assign f.r_pc_2    = f.r_valid_2 ? pc_mem[rptr_1]   : 32'h0;
  assign f.r_inst_2  = f.r_valid_2 ? inst_mem[rptr_1] : 32'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (f.fifo_flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + AW'(rn);
      wptr  <= wptr + AW'(wn);
      count <= count + (AW+1)'(wn) - (AW+1)'(rn);
    end
  end
  // Storage is never cleared; valid flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && !f.fifo_flush && wn != 2'd0) begin
      pc_mem[wptr]   <= f.w_pc_1;
      inst_mem[wptr] <= f.w_inst_1;
      if (wn == 2'd2) begin
        pc_mem[wptr_1]   <= f.w_pc_2;
        inst_mem[wptr_1] <= f.w_inst_2;
      end
    end
  end
endmodule
